// File: rtl/mem_bus_responder.sv
// rtl/mem_bus_responder.sv - memory bus responder with bounded random grant stalls and range errors
//
// Purpose:
//   Models the core's instruction or data memory bus target. A word-addressed
//   RAM answers requests one cycle after they are granted. Grants are delayed
//   by a pseudo-random number of cycles (0..MAX_STALL) drawn from a 16-bit
//   LFSR. Addresses beyond the RAM return a bus error and never touch the RAM.
//
// Ports:
//   g_clk         global clock
//   g_resetn      asynchronous active-low reset
//   mem_req       request valid, held by the initiator until granted
//   mem_addr      request byte address
//   mem_wen       1 = write, 0 = read
//   mem_strb      write byte enables, one per data byte
//   mem_wdata     write data
//   cfg_stall_en  1 = random grant stalls, 0 = grant immediately
//   mem_gnt       request accepted this cycle (combinational)
//   mem_err       registered error, valid in the response cycle only
//   mem_rdata     registered read data, valid in the response cycle
module mem_bus_responder #(
  parameter int          MEM_ADDR_W = 64,
  parameter int          MEM_DATA_W = 64,
  parameter int          MEM_STRB_W = 8,
  parameter int          DEPTH_W    = 10,
  parameter int          MAX_STALL  = 4,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                  g_clk,
  input  logic                  g_resetn,
  input  logic                  mem_req,
  input  logic [MEM_ADDR_W-1:0] mem_addr,
  input  logic                  mem_wen,
  input  logic [MEM_STRB_W-1:0] mem_strb,
  input  logic [MEM_DATA_W-1:0] mem_wdata,
  input  logic                  cfg_stall_en,
  output logic                  mem_gnt,
  output logic                  mem_err,
  output logic [MEM_DATA_W-1:0] mem_rdata
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam int          DEPTH     = 1 << DEPTH_W;
  localparam logic [15:0] STALL_MOD = 16'(MAX_STALL + 1);

  state_t               state;
  logic [3:0]           stall_cnt;
  logic [15:0]          lfsr;
  logic                 lfsr_fb;
  logic [3:0]           draw;
  logic [DEPTH_W-1:0]   idx;
  logic                 out_of_range;
  logic                 ram_we;
  logic                 unused_addr_lo;

  logic [MEM_DATA_W-1:0] ram [DEPTH];

  // Fibonacci LFSR, taps 16,14,13,11, shifting towards bit 0.
  assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  // Stall length for a request that starts this cycle.
  assign draw = cfg_stall_en ? 4'(lfsr % STALL_MOD) : 4'd0;

  assign idx            = mem_addr[DEPTH_W+2:3];
  assign out_of_range   = |mem_addr[MEM_ADDR_W-1:DEPTH_W+3];
  // Byte offset inside a word is irrelevant; sub-word writes use strobes.
  assign unused_addr_lo = ^mem_addr[2:0];

  // Grant is combinational so a zero-stall request completes in one cycle.
  // Reset forces it low so a request held through reset is simply dropped.
  always_comb begin
    mem_gnt = 1'b0;
    if (g_resetn && mem_req) begin
      case (state)
        ST_IDLE: mem_gnt = (draw == 4'd0);
        ST_WAIT: mem_gnt = (stall_cnt == 4'd0);
        default: mem_gnt = 1'b0;
      endcase
    end
  end

  assign ram_we = mem_gnt && mem_wen && !out_of_range;

  // Stall FSM and LFSR.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state     <= ST_IDLE;
      stall_cnt <= 4'd0;
      lfsr      <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr_fb, lfsr[15:1]};
      case (state)
        ST_IDLE: begin
          // The IDLE cycle itself is the first stall cycle, hence draw-1.
          if (mem_req && (draw != 4'd0)) begin
            state     <= ST_WAIT;
            stall_cnt <= draw - 4'd1;
          end
        end
        ST_WAIT: begin
          // A dropped request abandons the wait; the next one draws afresh.
          if (!mem_req || (stall_cnt == 4'd0)) begin
            state <= ST_IDLE;
          end else begin
            stall_cnt <= stall_cnt - 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Response registers. Reading ram here returns the pre-write word even if
  // the same cycle were to write it.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      mem_err   <= 1'b0;
      mem_rdata <= '0;
    end else if (mem_gnt) begin
      mem_err   <= out_of_range;
      mem_rdata <= (out_of_range || mem_wen) ? '0 : ram[idx];
    end else begin
      mem_err   <= 1'b0;
    end
  end

  // RAM storage, not reset.
  always_ff @(posedge g_clk) begin
    if (ram_we) begin
      for (int i = 0; i < MEM_STRB_W; i++) begin
        if (mem_strb[i]) begin
          ram[idx][i*8 +: 8] <= mem_wdata[i*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// tb/tb_mem_bus_responder.sv - randomized self-checking bench for mem_bus_responder
module tb_mem_bus_responder;

  localparam int          MAX_STALL = 4;
  localparam logic [15:0] SEED      = 16'hACE1;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_wen;
  logic [7:0]  mem_strb;
  logic [63:0] mem_wdata;
  logic        cfg_stall_en;
  logic        mem_gnt;
  logic        mem_err;
  logic [63:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 g_clk = ~g_clk;

  mem_bus_responder #(
    .MEM_ADDR_W(64),
    .MEM_DATA_W(64),
    .MEM_STRB_W(8),
    .DEPTH_W(10),
    .MAX_STALL(MAX_STALL),
    .LFSR_SEED(SEED)
  ) dut (
    .g_clk(g_clk),
    .g_resetn(g_resetn),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_wen(mem_wen),
    .mem_strb(mem_strb),
    .mem_wdata(mem_wdata),
    .cfg_stall_en(cfg_stall_en),
    .mem_gnt(mem_gnt),
    .mem_err(mem_err),
    .mem_rdata(mem_rdata)
  );

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] fill_val(input int i);
    return {16'hF00D, 16'(i), 32'h12345678 ^ 32'(i)};
  endfunction

  function automatic int unsigned lfsr_next(input int unsigned v);
    int unsigned b;
    b = (v ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
    return (v >> 1) | (b << 15);
  endfunction

  // Reference model: a request that starts when no wait is pending draws s
  // and must be granted exactly s cycles later if req stays high.
  logic [63:0] m_ram [1024];
  int unsigned m_lfsr;
  bit          m_pend;
  int          m_elapsed;
  int          m_target;
  bit          m_rv;
  bit          m_rerr;
  logic [63:0] m_rdata;
  logic [63:0] m_last;

  always @(negedge g_clk) begin
    int s;
    bit eg;
    bit oor;
    int ix;
    if (!g_resetn) begin
      check64("reset_gnt", 64'(mem_gnt), 64'd0);
      check64("reset_err", 64'(mem_err), 64'd0);
      check64("reset_rdata", mem_rdata, 64'd0);
      m_lfsr = 32'(SEED);
      m_pend = 1'b0;
      m_rv   = 1'b0;
      m_last = 64'd0;
    end else begin
      eg = 1'b0;
      if (mem_req) begin
        if (!m_pend) begin
          s = cfg_stall_en ? int'(m_lfsr % (MAX_STALL + 1)) : 0;
          if (s == 0) eg = 1'b1;
          else begin
            m_pend    = 1'b1;
            m_elapsed = 0;
            m_target  = s;
          end
        end else begin
          m_elapsed++;
          if (m_elapsed == m_target) begin
            eg     = 1'b1;
            m_pend = 1'b0;
          end
        end
      end else begin
        m_pend = 1'b0;
      end
      check64("gnt", 64'(mem_gnt), 64'(eg));
      if (m_rv) begin
        check64("resp_err", 64'(mem_err), 64'(m_rerr));
        check64("resp_rdata", mem_rdata, m_rdata);
      end else begin
        check64("idle_err", 64'(mem_err), 64'd0);
        check64("idle_rdata_hold", mem_rdata, m_last);
      end
      m_rv = eg;
      if (eg) begin
        oor     = (mem_addr >> 13) != 64'd0;
        ix      = int'(mem_addr[12:3]);
        m_rerr  = oor;
        m_rdata = 64'd0;
        if (!oor) begin
          if (mem_wen) begin
            for (int b = 0; b < 8; b++)
              if (mem_strb[b]) m_ram[ix][b*8 +: 8] = mem_wdata[b*8 +: 8];
          end else begin
            m_rdata = m_ram[ix];
          end
        end
        m_last = m_rdata;
      end
      m_lfsr = lfsr_next(m_lfsr);
    end
  end

  // Present a request at posedge+1 and hold it until granted; returns at
  // posedge+1 after the grant edge with the stall count observed.
  task automatic issue(input logic [63:0] a, input logic w, input logic [7:0] st,
                       input logic [63:0] d, input bit drop, output int stalls);
    bit got;
    got       = 1'b0;
    stalls    = 0;
    mem_req   = 1'b1;
    mem_addr  = a;
    mem_wen   = w;
    mem_strb  = st;
    mem_wdata = d;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge g_clk);
      if (mem_gnt) got = 1'b1;
      else stalls++;
      @(posedge g_clk);
      #1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL gnt_timeout: no grant within 40 cycles, addr %h", a);
    end
    if (drop) mem_req = 1'b0;
  endtask

  task automatic get_resp(output logic e, output logic [63:0] r);
    @(negedge g_clk);
    e = mem_err;
    r = mem_rdata;
    @(posedge g_clk);
    #1;
  endtask

  initial begin
    int          st;
    int          st_max;
    bit          saw0;
    bit          saw4;
    bit          done;
    int          widx;
    logic        e;
    logic [63:0] r;
    logic [63:0] a;

    g_resetn = 1'b1; mem_req = 1'b0; mem_addr = '0; mem_wen = 1'b0;
    mem_strb = '0; mem_wdata = '0; cfg_stall_en = 1'b0;
    #1 g_resetn = 1'b0;
    #2;
    check64("por_gnt", 64'(mem_gnt), 64'd0);
    check64("por_err", 64'(mem_err), 64'd0);
    check64("por_rdata", mem_rdata, 64'd0);
    repeat (2) @(posedge g_clk);
    #1 g_resetn = 1'b1;

    // Fill every word back to back with zero stall.
    for (int i = 0; i < 1024; i++) begin
      issue(64'(i) << 3, 1'b1, 8'hFF, fill_val(i), 1'b0, st);
      check64("fill_stall0", 64'(st), 64'd0);
    end
    mem_req = 1'b0;
    @(posedge g_clk); #1;

    issue(64'h40, 1'b1, 8'hFF, 64'h1122334455667788, 1'b1, st);
    check64("wr_stall0", 64'(st), 64'd0);
    get_resp(e, r);
    check64("wr_err", 64'(e), 64'd0);
    check64("wr_rdata", r, 64'd0);
    issue(64'h40, 1'b0, 8'h00, 64'd0, 1'b1, st);
    get_resp(e, r);
    check64("rd_full", r, 64'h1122334455667788);

    issue(64'h40, 1'b1, 8'h0F, 64'hFFFFFFFFAAAAAAAA, 1'b1, st);
    get_resp(e, r);
    issue(64'h40, 1'b0, 8'h00, 64'd0, 1'b1, st);
    get_resp(e, r);
    check64("rd_partial", r, 64'h11223344AAAAAAAA);

    issue(64'h2000, 1'b0, 8'h00, 64'd0, 1'b1, st);
    get_resp(e, r);
    check64("oor_rd_err", 64'(e), 64'd1);
    check64("oor_rd_rdata", r, 64'd0);
    issue(64'h2000, 1'b1, 8'hFF, 64'hDEADDEADDEADDEAD, 1'b1, st);
    get_resp(e, r);
    check64("oor_wr_err", 64'(e), 64'd1);
    issue(64'h0, 1'b0, 8'h00, 64'd0, 1'b1, st);
    get_resp(e, r);
    check64("oor_word0_intact", r, 64'hF00D000012345678);

    issue(64'h43, 1'b1, 8'h00, 64'h0, 1'b1, st);
    get_resp(e, r);
    check64("strb0_err", 64'(e), 64'd0);
    issue(64'h40, 1'b0, 8'h00, 64'd0, 1'b1, st);
    get_resp(e, r);
    check64("strb0_unchanged", r, 64'h11223344AAAAAAAA);

    issue(64'h80, 1'b1, 8'hFF, 64'hCAFEF00D0BADBEEF, 1'b0, st);
    issue(64'h80, 1'b0, 8'h00, 64'd0, 1'b1, st);
    get_resp(e, r);
    check64("raw_b2b", r, 64'hCAFEF00D0BADBEEF);

    // Random stalled traffic; writes stay in words 16..511.
    cfg_stall_en = 1'b1;
    st_max = 0; saw0 = 1'b0; saw4 = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      bit w;
      bit drop;
      w = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 99) < 5) a = {$urandom, $urandom} | 64'h2000;
      else if (w) a = 64'($urandom_range(16, 511)) << 3;
      else a = (64'($urandom_range(0, 1023)) << 3) | 64'($urandom_range(0, 7));
      drop = ($urandom_range(0, 3) == 0);
      issue(a, w, 8'($urandom), {$urandom, $urandom}, drop, st);
      checks++;
      if (st > MAX_STALL) begin
        errors++;
        $display("FAIL stall_bound: got %0d cycles, required at most %0d", st, MAX_STALL);
      end
      if (st == 0) saw0 = 1'b1;
      if (st == MAX_STALL) saw4 = 1'b1;
      if (drop) repeat ($urandom_range(0, 2)) begin @(posedge g_clk); #1; end
    end
    mem_req = 1'b0;
    @(posedge g_clk); #1;
    check64("saw_stall0", 64'(saw0), 64'd1);
    check64("saw_stall_max", 64'(saw4), 64'd1);

    // Drop a stalled request, then re-raise it.
    done = 1'b0;
    for (int t = 0; t < 30 && !done; t++) begin
      mem_req = 1'b1; mem_addr = 64'd20 << 3; mem_wen = 1'b0;
      @(negedge g_clk);
      if (mem_gnt) begin
        @(posedge g_clk); #1;
        mem_req = 1'b0;
        @(posedge g_clk); #1;
      end else begin
        @(posedge g_clk); #1;
        mem_req = 1'b0;
        done = 1'b1;
        repeat (3) begin
          @(negedge g_clk);
          check64("drop_no_gnt", 64'(mem_gnt), 64'd0);
          check64("drop_no_err", 64'(mem_err), 64'd0);
          @(posedge g_clk); #1;
        end
      end
    end
    check64("drop_exercised", 64'(done), 64'd1);
    issue(64'd20 << 3, 1'b0, 8'h00, 64'd0, 1'b1, st);
    get_resp(e, r);
    check64("drop_reraise_rd", r, m_ram[20]);

    // Reset while a write waits out its stall.
    done = 1'b0;
    widx = 600;
    for (int t = 0; t < 30 && !done; t++) begin
      widx = 600 + t;
      mem_req = 1'b1; mem_addr = 64'(widx) << 3; mem_wen = 1'b1;
      mem_strb = 8'hFF; mem_wdata = 64'h0BAD0BAD0BAD0BAD;
      @(negedge g_clk);
      if (mem_gnt) begin
        @(posedge g_clk); #1;
        mem_req = 1'b0;
        @(posedge g_clk); #1;
      end else begin
        @(posedge g_clk); #2;
        g_resetn = 1'b0;
        #1;
        check64("midwait_rst_gnt", 64'(mem_gnt), 64'd0);
        check64("midwait_rst_err", 64'(mem_err), 64'd0);
        check64("midwait_rst_rdata", mem_rdata, 64'd0);
        mem_req = 1'b0;
        repeat (2) @(posedge g_clk);
        #1 g_resetn = 1'b1;
        done = 1'b1;
      end
    end
    check64("rst_exercised", 64'(done), 64'd1);
    cfg_stall_en = 1'b0;
    issue(64'(widx) << 3, 1'b0, 8'h00, 64'd0, 1'b1, st);
    get_resp(e, r);
    check64("rst_write_dropped", r, fill_val(widx));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
